// File: rtl/button_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : button_pkg                                                   |
// | Description : Shared types and helpers for the key event arbiter slice.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package button_pkg;

  localparam int KEY_NUM   = 4;
  localparam int KEY_IDX_W = 2;

  // Pointer reset value: KEY0 is the first index searched after reset
  localparam logic [KEY_IDX_W-1:0] c_rr_ptr_init = KEY_IDX_W'(KEY_NUM - 1);

  typedef struct packed {
    logic                 is_cmd;
    logic [KEY_IDX_W-1:0] code;
  } key_evt_t;

  // Round-robin pick: first requesting index strictly after ptr, wrapping,
  // with ptr itself searched last
  function automatic logic [KEY_IDX_W-1:0] rr_pick(
    input logic [KEY_NUM-1:0]   req,
    input logic [KEY_IDX_W-1:0] ptr
  );
    logic [KEY_IDX_W-1:0] idx;
    logic                 found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 1; k <= KEY_NUM; k++) begin
      idx = ptr + KEY_IDX_W'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_event_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : key_event_arbiter_if                                         |
// | Description : valid/ready event port carrying a tagged key index.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface key_event_arbiter_if;
  import button_pkg::*;

  logic                 EVT_VALID;
  logic                 EVT_READY;
  logic                 EVT_IS_CMD;
  logic [KEY_IDX_W-1:0] EVT_CODE;

  modport master (output EVT_VALID, output EVT_IS_CMD, output EVT_CODE, input EVT_READY);
  modport slave  (input EVT_VALID, input EVT_IS_CMD, input EVT_CODE, output EVT_READY);

endinterface
`default_nettype wire

// File: rtl/key_debouncer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : key_debouncer                                                |
// | Description : 2-FF synchroniser, counter debounce and press (fall) pulse   |
// |               for one raw board input.                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module key_debouncer #(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter int   CNT_W           = 20,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_pin,
  output logic      o_level,
  output logic      o_fall
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;

  // Bring the asynchronous pin into the clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= RESET_LEVEL;
      r_sync2 <= RESET_LEVEL;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after it has differed from the stable one for
  // DEBOUNCE_CYCLES consecutive cycles; flag a 1->0 acceptance as a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stable <= RESET_LEVEL;
      r_cnt    <= '0;
      r_fall   <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
        r_fall   <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_stable;
  assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/key_event_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : key_event_arbiter                                            |
// | Description : Debounces KEY[3:0] and SW[9], tags each press as CMD or KEY  |
// |               and round-robin arbitrates presses onto one valid/ready      |
// |               event port. Counts presses lost to a still-pending event.    |
// |               Optional macro BTN_AUTOREPEAT_EN adds hold-to-repeat.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module key_event_arbiter
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  wire logic               CLOCK_50,
  input  wire logic               RST,
  input  wire logic               SW,
  input  wire logic [KEY_NUM-1:0] KEY,
  key_event_arbiter_if.master     evt,
  output logic [7:0]              DROP_CNT
);

  logic [KEY_NUM-1:0]   w_key_level;
  logic [KEY_NUM-1:0]   w_key_fall;
  logic                 w_sw_level;
  logic                 w_sw_fall_unused;
  logic [KEY_NUM-1:0]   w_press;
  logic [KEY_NUM-1:0]   w_grant_vec;
  logic [KEY_NUM-1:0]   w_drop_vec;
  logic [2:0]           w_drop_num;
  logic [8:0]           w_drop_sum;
  logic [KEY_IDX_W-1:0] w_grant;
  logic                 w_out_free;
  logic                 w_load;

  logic [KEY_NUM-1:0]   r_pending;
  logic [KEY_NUM-1:0]   r_mode_tag;
  logic [KEY_IDX_W-1:0] r_rr_ptr;
  logic                 r_valid;
  key_evt_t             r_evt;
  logic [7:0]           r_drop_cnt;

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_key_db
    key_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .RESET_LEVEL     (1'b1)
    ) u_key_db (
      .clk     (CLOCK_50),
      .rst     (RST),
      .i_pin   (KEY[i]),
      .o_level (w_key_level[i]),
      .o_fall  (w_key_fall[i])
    );
  end

  // Mode switch only needs its level; its fall pulse has no consumer
  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .RESET_LEVEL     (1'b0)
  ) u_sw_db (
    .clk     (CLOCK_50),
    .rst     (RST),
    .i_pin   (SW),
    .o_level (w_sw_level),
    .o_fall  (w_sw_fall_unused)
  );

`ifdef BTN_AUTOREPEAT_EN
  localparam int c_rep_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_rep_w   = $clog2(c_rep_max + 1);

  logic [KEY_NUM-1:0] w_repeat;

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_repeat
    logic [c_rep_w-1:0] r_hold_cnt;
    logic               r_rep_phase;
    logic               w_hit;

    // First repeat after REPEAT_DELAY held cycles, then every REPEAT_PERIOD
    assign w_hit = ~w_key_level[i] &
                   (r_hold_cnt == (r_rep_phase ? c_rep_w'(REPEAT_PERIOD) : c_rep_w'(REPEAT_DELAY)));

    // Hold counter runs while the debounced key is pressed, clears on release
    always_ff @(posedge CLOCK_50 or posedge RST) begin
      if (RST) begin
        r_hold_cnt  <= '0;
        r_rep_phase <= 1'b0;
      end else if (w_key_level[i]) begin
        r_hold_cnt  <= '0;
        r_rep_phase <= 1'b0;
      end else if (w_hit) begin
        r_hold_cnt  <= c_rep_w'(1);
        r_rep_phase <= 1'b1;
      end else begin
        r_hold_cnt  <= r_hold_cnt + c_rep_w'(1);
      end
    end

    assign w_repeat[i] = w_hit;
  end

  assign w_press = w_key_fall | w_repeat;
`else
  // Repeat timing parameters are only consumed by the auto-repeat build
  localparam int c_repeat_cfg_unused = REPEAT_DELAY + REPEAT_PERIOD;

  assign w_press = w_key_fall;
`endif

  assign w_out_free = ~r_valid | evt.EVT_READY;
  assign w_load     = w_out_free & (|r_pending);
  assign w_grant    = rr_pick(r_pending, r_rr_ptr);

  // One-hot view of the key granted this cycle (zero when nothing loads)
  always_comb begin
    w_grant_vec          = '0;
    w_grant_vec[w_grant] = w_load;
  end

  // A press is lost only if its key is pending and not being granted now
  assign w_drop_vec = w_press & r_pending & ~w_grant_vec;

  // Number of presses lost this cycle
  always_comb begin
    w_drop_num = '0;
    for (int i = 0; i < KEY_NUM; i++) begin
      w_drop_num = w_drop_num + {2'b00, w_drop_vec[i]};
    end
  end

  assign w_drop_sum = {1'b0, r_drop_cnt} + {6'd0, w_drop_num};

  // Pending bits and mode tags: accepted presses set and tag, grants clear
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      r_pending  <= '0;
      r_mode_tag <= '0;
    end else begin
      for (int i = 0; i < KEY_NUM; i++) begin
        if (w_press[i] && !w_drop_vec[i]) begin
          r_pending[i]  <= 1'b1;
          r_mode_tag[i] <= w_sw_level;
        end else if (w_grant_vec[i]) begin
          r_pending[i]  <= 1'b0;
        end
      end
    end
  end

  // Output register: refills whenever empty or being accepted this cycle
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      r_valid  <= 1'b0;
      r_evt    <= '0;
      r_rr_ptr <= c_rr_ptr_init;
    end else if (w_load) begin
      r_valid      <= 1'b1;
      r_evt.code   <= w_grant;
      r_evt.is_cmd <= r_mode_tag[w_grant];
      r_rr_ptr     <= w_grant;
    end else if (w_out_free) begin
      r_valid <= 1'b0;
    end
  end

  // Saturating count of dropped presses
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      r_drop_cnt <= '0;
    end else begin
      r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  assign evt.EVT_VALID  = r_valid;
  assign evt.EVT_IS_CMD = r_evt.is_cmd;
  assign evt.EVT_CODE   = r_evt.code;
  assign DROP_CNT       = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_key_event_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_key_event_arbiter                                         |
// | Description : Random and directed stimulus for key_event_arbiter checked   |
// |               against a behavioural model (window debounce, event rules).  |
// |               Honours BTN_AUTOREPEAT_EN when defined.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_key_event_arbiter;

  localparam int D  = 8;
  localparam int RD = 40;
  localparam int RP = 16;

  logic       clk = 1'b0;
  logic       RST = 1'b0;
  logic       SW  = 1'b0;
  logic [3:0] KEY = 4'hF;
  logic [7:0] DROP_CNT;

  key_event_arbiter_if evt_if ();

  key_event_arbiter #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (4),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .CLOCK_50 (clk),
    .RST      (RST),
    .SW       (SW),
    .KEY      (KEY),
    .evt      (evt_if),
    .DROP_CNT (DROP_CNT)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_fire   = 0;
  int cyc      = 0;
  int fire_cyc[$];

  // Reference model state
  logic [D:0] m_hist [5];   // [0] = latest pin sample, [k] = k edges older
  logic [4:0] m_stab;       // accepted levels, bit 4 = SW
  logic [3:0] m_press;      // press seen by the event layer at the next edge
  logic [3:0] m_pend;
  logic [3:0] m_tag;
  int         m_ptr;
  int         m_code;
  int         m_drop;
  int         m_held [4];
  logic       m_valid;
  logic       m_cmd;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 5; j++) m_hist[j] = (j < 4) ? '1 : '0;
    m_stab  = 5'b01111;
    m_press = '0;
    m_pend  = '0;
    m_tag   = '0;
    m_ptr   = 3;
    m_code  = 0;
    m_drop  = 0;
    m_valid = 1'b0;
    m_cmd   = 1'b0;
    for (int i = 0; i < 4; i++) m_held[i] = 0;
  endtask

  task automatic model_step();
    logic [3:0] gv;
    logic [4:0] pins;
    logic [4:0] old;
    logic       found;
    int         g;
    if (RST) begin
      model_reset();
      return;
    end
    // event port: refill when empty or being taken
    gv = '0;
    if (!m_valid || evt_if.EVT_READY) begin
      if (m_pend != 0) begin
        found = 1'b0;
        g     = 0;
        for (int k = 1; k <= 4; k++) begin
          if (!found && m_pend[(m_ptr + k) % 4]) begin
            g     = (m_ptr + k) % 4;
            found = 1'b1;
          end
        end
        m_valid = 1'b1;
        m_code  = g;
        m_cmd   = m_tag[g];
        m_ptr   = g;
        gv[g]   = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    // presses: drop if the key still holds an unserved event
    for (int i = 0; i < 4; i++) begin
      if (m_press[i]) begin
        if (m_pend[i] && !gv[i]) begin
          if (m_drop < 255) m_drop++;
        end else begin
          m_pend[i] = 1'b1;
          m_tag[i]  = m_stab[4];
        end
      end else if (gv[i]) begin
        m_pend[i] = 1'b0;
      end
    end
    // debounce: a level is accepted once D consecutive synced samples show it
    pins = {SW, KEY};
    old  = m_stab;
    for (int j = 0; j < 5; j++) begin
      if (m_hist[j][D:1] == {D{~old[j]}}) m_stab[j] = ~old[j];
      m_hist[j] = {m_hist[j][D-1:0], pins[j]};
    end
    m_press = old[3:0] & ~m_stab[3:0];
`ifdef BTN_AUTOREPEAT_EN
    for (int i = 0; i < 4; i++) begin
      if (!m_stab[i]) begin
        m_held[i] = old[i] ? 0 : m_held[i] + 1;
        if (m_held[i] >= RD && ((m_held[i] - RD) % RP) == 0) m_press[i] = 1'b1;
      end else begin
        m_held[i] = 0;
      end
    end
`endif
  endtask

  task automatic compare_outputs();
    check("evt_valid",  int'(evt_if.EVT_VALID),  int'(m_valid));
    check("evt_code",   int'(evt_if.EVT_CODE),   m_code);
    check("evt_is_cmd", int'(evt_if.EVT_IS_CMD), int'(m_cmd));
    check("drop_cnt",   int'(DROP_CNT),          m_drop);
  endtask

  task automatic tick();
    if (!RST && evt_if.EVT_VALID && evt_if.EVT_READY) begin
      n_fire++;
      fire_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    compare_outputs();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge
  task automatic do_reset();
    RST = 1'b1;
    model_reset();
    #1;
    check("rst_valid",  int'(evt_if.EVT_VALID),  0);
    check("rst_code",   int'(evt_if.EVT_CODE),   0);
    check("rst_is_cmd", int'(evt_if.EVT_IS_CMD), 0);
    check("rst_drop",   int'(DROP_CNT),          0);
    tick();
    tick();
    RST = 1'b0;
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int f0;
    int key_left [4];
    int sw_left;
    int exp_off [5] = '{0, 40, 56, 72, 88};

    evt_if.EVT_READY = 1'b0;
    model_reset();
    #2;
    do_reset();
    repeat (5) tick();

    // Uncontended press on KEY2: latency and single event
    evt_if.EVT_READY = 1'b1;
    f0     = n_fire;
    KEY[2] = 1'b0;
    n      = 0;
    do begin
      tick();
      n++;
    end while (!evt_if.EVT_VALID && n < 40);
    check("latency", n, 12);
    check("k2_code", int'(evt_if.EVT_CODE), 2);
    repeat (20 - n) tick();
    KEY[2] = 1'b1;
    repeat (20) tick();
    check("k2_one_event", n_fire - f0, 1);

    // Bouncing KEY1 then steady low: one event only
    f0 = n_fire;
    for (int c = 0; c < 10; c++) begin
      KEY[1] = ~KEY[1];
      repeat (3) tick();
    end
    KEY[1] = 1'b0;
    repeat (25) tick();
    KEY[1] = 1'b1;
    repeat (20) tick();
    check("bounce_one_event", n_fire - f0, 1);

    // Simultaneous KEY0/KEY3 in command mode under back-pressure
    do_reset();
    SW = 1'b1;
    repeat (15) tick();
    evt_if.EVT_READY = 1'b0;
    KEY[0] = 1'b0;
    KEY[3] = 1'b0;
    repeat (22) tick();
    check("stall_code", int'(evt_if.EVT_CODE), 0);
    check("stall_cmd",  int'(evt_if.EVT_IS_CMD), 1);
    f0 = n_fire;
    fire_cyc.delete();
    evt_if.EVT_READY = 1'b1;
    repeat (5) tick();
    check("pair_events", n_fire - f0, 2);
    KEY = 4'hF;
    repeat (15) tick();

    // Repeated KEY2 presses while the consumer stalls: one press dropped
    do_reset();
    SW = 1'b0;
    evt_if.EVT_READY = 1'b0;
    for (int p = 0; p < 3; p++) begin
      KEY[2] = 1'b0;
      repeat (12) tick();
      KEY[2] = 1'b1;
      repeat (12) tick();
    end
    check("drop_one", int'(DROP_CNT), 1);
    evt_if.EVT_READY = 1'b1;
    repeat (10) tick();

    // Drop counter saturation
    evt_if.EVT_READY = 1'b0;
    for (int p = 0; p < 260; p++) begin
      KEY[0] = 1'b0;
      repeat (11) tick();
      KEY[0] = 1'b1;
      repeat (11) tick();
    end
    check("drop_saturate", int'(DROP_CNT), 255);

    // Reset while an event is presented and another pending; KEY1 held through
    do_reset();
    evt_if.EVT_READY = 1'b0;
    KEY[0] = 1'b0;
    KEY[1] = 1'b0;
    repeat (14) tick();
    KEY[0] = 1'b1;
    tick();
    #2;
    do_reset();
    f0 = n_fire;
    evt_if.EVT_READY = 1'b1;
    repeat (20) tick();
    KEY[1] = 1'b1;
    repeat (20) tick();
    check("held_through_reset", n_fire - f0, 1);

`ifdef BTN_AUTOREPEAT_EN
    // Held KEY3 with auto-repeat
    do_reset();
    evt_if.EVT_READY = 1'b1;
    fire_cyc.delete();
    KEY[3] = 1'b0;
    repeat (100) tick();
    KEY[3] = 1'b1;
    repeat (30) tick();
    check("repeat_count", fire_cyc.size(), 5);
    if (fire_cyc.size() == 5) begin
      for (int k = 1; k < 5; k++) check("repeat_offset", fire_cyc[k] - fire_cyc[0], exp_off[k]);
    end
`endif

    // Random keys, mode switch and consumer stalls
    for (int i = 0; i < 4; i++) key_left[i] = $urandom_range(2, 30);
    sw_left = $urandom_range(5, 60);
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (key_left[i] == 0) begin
          KEY[i]      = ~KEY[i];
          key_left[i] = $urandom_range(2, 30);
        end else begin
          key_left[i]--;
        end
      end
      if (sw_left == 0) begin
        SW      = ~SW;
        sw_left = $urandom_range(5, 60);
      end else begin
        sw_left--;
      end
      evt_if.EVT_READY = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
